// File: rtl/i2c_eeprom_seq.sv
// i2c_eeprom_seq: I2C slave sequencer for a 256-byte EEPROM array (32 pages x 8 bytes).
// Oversamples SCL/SDA on clk and decodes START/STOP, the device address, the word
// address and data bytes. It handles byte writes, page-wrapped writes and sequential reads.
// Optional feature macro: I2C_EEPROM_WP_EN adds the wp input. While wp=1, data bytes are
// NACKed and are not written.
`timescale 1ns/1ps
module i2c_eeprom_seq #(
  parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
`ifdef I2C_EEPROM_WP_EN
  input  logic       wp,
`endif
  output logic       sda_oe,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, WORDADDR, WAACK, WRDATA, WRACK, RDDATA, RDACK
  } state_t;

  logic       wp_act;
`ifdef I2C_EEPROM_WP_EN
  assign wp_act = wp;
`else
  assign wp_act = 1'b0;
`endif

  // The synchronisers reset to the idle-bus level, so releasing reset never fakes a START.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;

  // Two-flop synchronisers plus one delayed copy of each signal for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // shreg holds the 7 bits already received; the 8th bit comes straight from sda_s.
  // During reads it holds the bits still to be sent.
  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_n;
  logic [6:0] shreg, sh_n;
  logic [7:0] addr_n, wdata_n, byte_in;
  logic       oe_n, we_n, busy_n;
  logic       rw, rw_n;
  logic       ack_ph, ph_n;   // 0: waiting for the fall that opens the ACK slot, 1: inside it
  logic       blk, blk_n;     // the current data byte was refused (write-protect)
  logic       byte_done;

  assign byte_in   = {shreg, sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      mem_addr  <= 8'd0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      sda_oe    <= 1'b0;
      rw        <= 1'b0;
      ack_ph    <= 1'b0;
      blk       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_n;
      shreg     <= sh_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_we    <= we_n;
      sda_oe    <= oe_n;
      rw        <= rw_n;
      ack_ph    <= ph_n;
      blk       <= blk_n;
      busy      <= busy_n;
    end
  end

  // Next-state logic. Bits are sampled on SCL rise, and SDA is driven only on SCL fall.
  // mem_addr mirrors the address register at all times. mem_rdata therefore settles long
  // before the SCL fall that starts a read byte.
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    we_n    = 1'b0;
    oe_n    = sda_oe;
    rw_n    = rw;
    ph_n    = ack_ph;
    blk_n   = blk;
    if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else if (start_det) begin
      state_n = DEVADDR;
      bit_n   = 3'd0;
      oe_n    = 1'b0;
    end else begin
      case (state)
        DEVADDR: if (scl_rise) begin
          sh_n  = byte_in[6:0];
          bit_n = bit_cnt + 3'd1;
          if (byte_done) begin
            ph_n = 1'b0;
            if (byte_in[7:1] == DEV_ADDR) begin
              state_n = DEVACK;
              rw_n    = byte_in[0];
            end else begin
              state_n = IDLE;
            end
          end
        end
        WORDADDR: if (scl_rise) begin
          sh_n  = byte_in[6:0];
          bit_n = bit_cnt + 3'd1;
          if (byte_done) begin
            addr_n  = byte_in;
            ph_n    = 1'b0;
            state_n = WAACK;
          end
        end
        WRDATA: if (scl_rise) begin
          sh_n  = byte_in[6:0];
          bit_n = bit_cnt + 3'd1;
          if (byte_done) begin
            blk_n   = wp_act;
            we_n    = ~wp_act;
            wdata_n = byte_in;
            ph_n    = 1'b0;
            state_n = WRACK;
          end
        end
        DEVACK, WAACK, WRACK: if (scl_fall) begin
          bit_n = 3'd0;
          if (!ack_ph) begin
            ph_n = 1'b1;
            oe_n = (state == WRACK) ? ~blk : 1'b1;
          end else begin
            ph_n = 1'b0;
            oe_n = 1'b0;
            if (state == DEVACK && rw) begin
              state_n = RDDATA;
              sh_n    = mem_rdata[6:0];
              oe_n    = ~mem_rdata[7];
            end else if (state == DEVACK) begin
              state_n = WORDADDR;
            end else begin
              state_n = WRDATA;
              if (state == WRACK && !blk)
                addr_n = {mem_addr[7:3], mem_addr[2:0] + 3'd1};
            end
          end
        end
        RDDATA: begin
          if (scl_rise) begin
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ph_n    = 1'b0;
              state_n = RDACK;
            end
          end else if (scl_fall) begin
            oe_n = ~shreg[6];
            sh_n = {shreg[5:0], 1'b0};
          end
        end
        RDACK: begin
          if (scl_fall && !ack_ph) begin
            oe_n = 1'b0;
            ph_n = 1'b1;
          end else if (scl_rise && ack_ph) begin
            if (sda_s) state_n = IDLE;
            else       addr_n  = mem_addr + 8'd1;
          end else if (scl_fall && ack_ph) begin
            ph_n    = 1'b0;
            bit_n   = 3'd0;
            state_n = RDDATA;
            sh_n    = mem_rdata[6:0];
            oe_n    = ~mem_rdata[7];
          end
        end
        default: oe_n = 1'b0;
      endcase
    end
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Directed bench for i2c_eeprom_seq. A bus-functional I2C master drives SCL/SDA. Expected
// bus responses and memory writes are queued as the stimulus is issued. Two monitors pop
// and compare them when the bus master finishes a byte and when mem_we fires.
`timescale 1ns/1ps
module tb_i2c_eeprom_seq;
  localparam time Q = 50ns;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1, sda_m = 1'b1, wp = 1'b0, preload = 1'b1;
  logic       sda_oe, mem_we, busy, sda_line;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];

  int n_chk = 0, n_bad = 0;
  logic [8:0]  exp_q[$], obs_q[$];
  logic [15:0] wr_q[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_seq dut (
    .clk(clk), .reset_n(reset_n), .scl_i(scl), .sda_i(sda_line),
`ifdef I2C_EEPROM_WP_EN
    .wp(wp),
`endif
    .sda_oe(sda_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: preload is mem[i] = i ^ 0x35, and reads have a 1-clk registered latency
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h35;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Bus monitor: compares each completed 9-bit slot observation against the expectation
  always @(negedge clk) begin
    if (obs_q.size() > 0) begin
      logic [8:0] o;
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL bus_unexp: got %h want none", o);
      end else begin
        chk("bus_byte", 32'(o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Write monitor: every mem_we pulse must match the next queued {addr, data}
  always @(negedge clk) begin
    if (mem_we && reset_n) begin
      if (wr_q.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL wr_unexp: got %h want none", {mem_addr, mem_wdata});
      end else begin
        chk("mem_write", 32'({mem_addr, mem_wdata}), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; #Q; scl = 1'b1; #Q; s = sda_line; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic xfer(input logic [8:0] tx, input logic [8:0] exp);
    logic [8:0] rx;
    logic       s;
    exp_q.push_back(exp);
    for (int i = 8; i >= 0; i--) begin
      clk_bit(tx[i], s);
      rx[i] = s;
    end
    obs_q.push_back(rx);
  endtask

  // Master sends b. The slave is expected to ACK (line low in slot 9) when ack=1.
  task automatic wr_byte(input logic [7:0] b, input logic ack);
    xfer({b, 1'b1}, {b, ~ack});
  endtask

  // Master reads and expects d. mack=1 means the master ACKs the byte.
  task automatic rd_byte(input logic [7:0] d, input logic mack);
    xfer({8'hFF, ~mack}, {d, ~mack});
  endtask

  initial begin
    logic s;
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    preload = 1'b0;
    reset_n = 1'b1;
    #(2*Q);

    // Single byte write
    i2c_start();
    chk("busy_after_start", 32'(busy), 1);
    wr_q.push_back(16'h125A);
    wr_byte(8'hA0, 1'b1); wr_byte(8'h12, 1'b1); wr_byte(8'h5A, 1'b1);
    i2c_stop(); #Q;
    chk("busy_after_stop", 32'(busy), 0);

    // Page write wrapping from 0x3F back to 0x38
    i2c_start();
    wr_byte(8'hA0, 1'b1); wr_byte(8'h3E, 1'b1);
    wr_q.push_back(16'h3E11); wr_q.push_back(16'h3F22);
    wr_q.push_back(16'h3833); wr_q.push_back(16'h3944);
    wr_byte(8'h11, 1'b1); wr_byte(8'h22, 1'b1); wr_byte(8'h33, 1'b1); wr_byte(8'h44, 1'b1);
    i2c_stop(); #Q;

    // Random read at 0xFF, then a sequential read that wraps to 0x00
    i2c_start();
    wr_byte(8'hA0, 1'b1); wr_byte(8'hFF, 1'b1);
    i2c_start();
    wr_byte(8'hA1, 1'b1);
    rd_byte(8'hCA, 1'b1);
    rd_byte(8'h35, 1'b0);
    i2c_stop(); #Q;
    chk("busy_after_read", 32'(busy), 0);

    // Wrong device address: no ACK, and the following byte is ignored
    i2c_start();
    wr_byte(8'hB0, 1'b0);
    chk("busy_after_nomatch", 32'(busy), 0);
    wr_byte(8'h55, 1'b0);
    i2c_stop(); #Q;

    // A partial byte followed by STOP must neither write nor move the address (stays 0x21)
    i2c_start();
    wr_byte(8'hA0, 1'b1); wr_byte(8'h20, 1'b1);
    wr_q.push_back(16'h2011);
    wr_byte(8'h11, 1'b1);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b0, s);
    i2c_stop(); #Q;
    i2c_start();
    wr_byte(8'hA1, 1'b1);
    rd_byte(8'h14, 1'b0);
    i2c_stop(); #Q;

    // Reset while the slave drives bit 7 of 0x75 (a 0): SDA must release immediately
    i2c_start();
    wr_byte(8'hA0, 1'b1); wr_byte(8'h40, 1'b1);
    i2c_start();
    wr_byte(8'hA1, 1'b1);
    chk("rd_driving", 32'(sda_oe), 1);
    reset_n = 1'b0; #1;
    chk("rst_mid_sda_oe", 32'(sda_oe), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_addr", 32'(mem_addr), 0);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    reset_n = 1'b1; #(2*Q);
    // After reset, the address register is 0, so a current-address read returns mem[0]
    i2c_start();
    wr_byte(8'hA1, 1'b1);
    rd_byte(8'h35, 1'b0);
    i2c_stop(); #Q;

`ifdef I2C_EEPROM_WP_EN
    // Write-protected: both address bytes are ACKed, the data byte is NACKed and not written
    wp = 1'b1;
    i2c_start();
    wr_byte(8'hA0, 1'b1); wr_byte(8'h10, 1'b1); wr_byte(8'h77, 1'b0);
    i2c_stop(); #Q;
    wp = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("bus_drained", 32'(exp_q.size()), 0);
    chk("writes_drained", 32'(wr_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
